load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, issues an aligned word access with
// byte enables, and returns sign/zero-extended load data or an alignment/illegal error.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            we_q;
  logic            err_q;
  logic [4:0]      rd_q;

  logic [1:0]            off;
  logic                  bad;
  logic [3:0]            be_n;
  logic [DATA_WIDTH-1:0] wd_n;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign req_ready = (state == IDLE);
  assign off       = req_addr[1:0];

  // Byte/half store data is replicated into every lane, which equals the
  // lane-shifted value in whichever lanes the byte enables select.
  always_comb begin
    bad  = 1'b0;
    be_n = 4'b0000;
    wd_n = req_wdata;
    case (req_funct3)
      3'b000, 3'b100: begin
        be_n = 4'b0001 << off;
        wd_n = {(DATA_WIDTH/8){req_wdata[7:0]}};
        bad  = req_we & req_funct3[2];
      end
      3'b001, 3'b101: begin
        be_n = 4'b0011 << off;
        wd_n = {(DATA_WIDTH/16){req_wdata[15:0]}};
        bad  = off[0] | (req_we & req_funct3[2]);
      end
      3'b010: begin
        be_n = 4'b1111;
        bad  = |off;
      end
      default: bad = 1'b1;
    endcase
  end

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = lane;
    case (f3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  // Errored requests pass one cycle through ACCESS with mem_req held low so that
  // every response, good or bad, arrives no earlier than two cycles after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state     <= ACCESS;
          f3_q      <= req_funct3;
          off_q     <= off;
          we_q      <= req_we;
          err_q     <= bad;
          rd_q      <= req_rd;
          mem_req   <= ~bad;
          mem_we    <= req_we & ~bad;
          mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be    <= bad ? 4'b0000 : be_n;
          mem_wdata <= wd_n;
        end
        ACCESS: if (err_q || mem_ack) begin
          state     <= RESP;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
          rsp_valid <= 1'b1;
          rsp_rd    <= rd_q;
          rsp_err   <= err_q;
          rsp_rdata <= (err_q || we_q) ? '0 : ld_ext;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random ops checked against an
// arithmetic model of alignment, byte enables, lane placement and load extension.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic bit m_err(input bit we, input bit [2:0] f3, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if ((f3 % 4) == 1 && (a % 2) != 0) return 1'b1;
    if ((f3 % 4) == 2 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_bytes(input bit [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [3:0] m_be(input bit [2:0] f3, input logic [31:0] addr);
    int mask = ((1 << m_bytes(f3)) - 1) << (addr % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_load(input bit [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int     n = m_bytes(f3);
    longint v = longint'({32'd0, rdata}) >> (8 * (addr % 4));
    v = v % (longint'(1) << (8 * n));
    if (f3 < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic drive_req(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
  endtask

  // One full transaction starting from IDLE; ack comes after 'waits' wait states.
  task automatic do_req(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic [4:0] rd, input string tag);
    bit          e;
    logic [31:0] exp_ld;
    logic [3:0]  be;
    int          off;
    e      = m_err(we, f3, addr);
    exp_ld = (e || we) ? 32'd0 : m_load(f3, addr, rdata);
    be     = m_be(f3, addr);
    off    = int'(addr % 4);
    chk({tag, "_rdy_idle"}, {31'd0, req_ready}, 32'd1);
    drive_req(we, f3, addr, wdata, rd);
    mem_ack   = 1'($urandom % 2);
    mem_rdata = $urandom;
    tick;
    // scramble request fields after accept: the unit must have registered them
    req_valid  = 1'b0;
    req_we     = 1'($urandom % 2);
    req_funct3 = 3'($urandom % 8);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd     = 5'($urandom % 32);
    mem_ack    = 1'b0;
    if (e) begin
      chk({tag, "_err_nomemreq"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_err_rdy"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_err_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
      tick;
    end else begin
      for (int i = 0; i <= waits; i++) begin
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, be});
        chk({tag, "_rdy_busy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
        if (we) begin
          for (int k = 0; k < 4; k++) begin
            if (be[k]) chk({tag, "_st_lane"}, (mem_wdata >> (8 * k)) & 32'hFF,
                           (wdata >> (8 * (k - off))) & 32'hFF);
          end
        end
        mem_ack   = (i == waits);
        mem_rdata = (i == waits) ? rdata : $urandom;
        tick;
      end
    end
    mem_ack = 1'b0;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, e});
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_ld);
    chk({tag, "_rsp_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
    chk({tag, "_rdy_resp"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_memreq_resp"}, {31'd0, mem_req}, 32'd0);
    mem_ack = 1'($urandom % 2);
    tick;
    mem_ack = 1'b0;
    chk({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_hold_rdata"}, rsp_rdata, exp_ld);
    chk({tag, "_hold_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
    chk({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, e});
    chk({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick;
    tick;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    rst_n = 1'b1;
    tick;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // directed scenarios
    do_req(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 3, 5'd7, "lw_wait3");
    chk("lw_const", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 0, 5'd1, "lb");
    chk("lb_const", rsp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000, 1, 5'd2, "lbu");
    chk("lbu_const", rsp_rdata, 32'h0000_0080);
    do_req(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 5'd9, "sh");
    chk("sh_const", rsp_rdata, 32'd0);
    do_req(1'b0, 3'b010, 32'h101, 32'd0, 32'h5555_5555, 0, 5'd4, "lw_mis");
    chk("lw_mis_const", {31'd0, rsp_err}, 32'd1);
    do_req(1'b1, 3'b100, 32'h40, 32'h1, 32'd0, 0, 5'd5, "sbu_illegal");
    do_req(1'b0, 3'b111, 32'h40, 32'h1, 32'd0, 0, 5'd6, "f3_illegal");
    do_req(1'b0, 3'b101, 32'h2E, 32'd0, 32'h9876_5432, 2, 5'd8, "lhu_hi");

    // reset in ACCESS abandons the access; a late ack must not revive it
    drive_req(1'b0, 3'b010, 32'h40, 32'd0, 5'd3);
    tick;
    req_valid = 1'b0;
    chk("rstacc_memreq_before", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    chk("rstacc_memreq", {31'd0, mem_req}, 32'd0);
    chk("rstacc_ready", {31'd0, req_ready}, 32'd1);
    tick;
    mem_ack = 1'b0;
    chk("rstacc_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rstacc_ready2", {31'd0, req_ready}, 32'd1);
    chk("rstacc_memreq2", {31'd0, mem_req}, 32'd0);
    tick;
    chk("rstacc_no_rsp2", {31'd0, rsp_valid}, 32'd0);

    // req_valid held high across two loads: no overlap
    drive_req(1'b0, 3'b010, 32'h300, 32'd0, 5'd3);
    tick;
    chk("b2b_a_addr", mem_addr, 32'h300);
    chk("b2b_rdy_access", {31'd0, req_ready}, 32'd0);
    drive_req(1'b0, 3'b010, 32'h304, 32'd0, 5'd4);
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick;
    mem_ack = 1'b0;
    chk("b2b_a_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_a_data", rsp_rdata, 32'h1111_1111);
    chk("b2b_rdy_resp", {31'd0, req_ready}, 32'd0);
    tick;
    chk("b2b_rdy_idle", {31'd0, req_ready}, 32'd1);
    chk("b2b_idle_memreq", {31'd0, mem_req}, 32'd0);
    tick;
    req_valid = 1'b0;
    chk("b2b_b_memreq", {31'd0, mem_req}, 32'd1);
    chk("b2b_b_addr", mem_addr, 32'h304);
    chk("b2b_b_rdy", {31'd0, req_ready}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h2222_2222;
    tick;
    mem_ack = 1'b0;
    chk("b2b_b_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_b_data", rsp_rdata, 32'h2222_2222);
    chk("b2b_b_rd", {27'd0, rsp_rd}, 32'd4);
    tick;

    // random traffic, biased toward legal ops
    for (int t = 0; t < 150; t++) begin
      bit          we;
      bit [2:0]    f3;
      logic [31:0] addr;
      we   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      if ($urandom % 4 != 0) f3 = we ? 3'($urandom % 3) : ((($urandom % 2) != 0) ? 3'($urandom % 3)
                                                                             : 3'(4 + $urandom % 2));
      addr = ($urandom & 32'h0000_FFFF);
      if ($urandom % 3 != 0) addr = addr & ~((32'd1 << (f3 % 4)) - 32'd1);
      do_req(we, f3, addr, $urandom, $urandom, int'($urandom % 4), 5'($urandom % 32), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
